// File: rtl/seq_u_div_rst.sv
// Multi-cycle unsigned restoring divider, radix-2: q = a / b, r = a % b.
// Operands and results move through valid/ready handshakes; one quotient bit per clock.
module seq_u_div_rst #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dbz
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;

  logic [N+1:0]  trial;
  logic [N:0]    rem_shift;
  logic          trial_neg;
  logic          last_iter;

  // {rem,quo} shifted left by one; the trial keeps an extra sign bit so a borrow is visible.
  always_comb begin
    rem_shift = {rem_q[N-1:0], quo_q[N-1]};
    trial     = {rem_q, quo_q[N-1]} - {2'b00, div_q};
    trial_neg = trial[N+1];
    last_iter = (cnt_q == CntW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (b == '0) begin
            state_d = StDone;
            q_d     = '1;
            r_d     = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = StCalc;
            rem_d   = '0;
            quo_d   = a;
            div_d   = b;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end
        end
      end

      StCalc: begin
        if (!trial_neg) begin
          rem_d = trial[N:0];
        end else begin
          rem_d = rem_shift;
        end
        quo_d = {quo_q[N-2:0], ~trial_neg};
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StDone;
          q_d     = quo_d;
          r_d     = rem_d[N-1:0];
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_u_div_rst.sv
// Bench for seq_u_div_rst: N=8 and N=5 instances checked every cycle against an arithmetic
// model of the handshake and result, plus directed vectors with literal expectations.
module tb_seq_u_div_rst;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, dbz8;
  logic [7:0] a8, b8, q8, r8;
  logic       in_valid5, in_ready5, out_valid5, out_ready5, dbz5;
  logic [4:0] a5, b5, q5, r5;

  seq_u_div_rst #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .q(q8), .r(r8), .dbz(dbz8)
  );

  seq_u_div_rst #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5), .a(a5), .b(b5),
    .out_valid(out_valid5), .out_ready(out_ready5), .q(q5), .r(r5), .dbz(dbz5)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Uniform views of both instances (index 0: N=8, index 1: N=5).
  logic [7:0] v_a[2], v_b[2], v_q[2], v_r[2];
  logic       v_iv[2], v_or[2], v_ir[2], v_ov[2], v_dbz[2];
  always_comb begin
    v_a[0] = a8;  v_a[1] = {3'b000, a5};
    v_b[0] = b8;  v_b[1] = {3'b000, b5};
    v_q[0] = q8;  v_q[1] = {3'b000, q5};
    v_r[0] = r8;  v_r[1] = {3'b000, r5};
    v_iv[0] = in_valid8;  v_iv[1] = in_valid5;
    v_or[0] = out_ready8; v_or[1] = out_ready5;
    v_ir[0] = in_ready8;  v_ir[1] = in_ready5;
    v_ov[0] = out_valid8; v_ov[1] = out_valid5;
    v_dbz[0] = dbz8;      v_dbz[1] = dbz5;
  end

  // Model: a busy/valid flag pair, remaining-edge countdown, and results from / and %.
  logic m_busy[2]  = '{1'b0, 1'b0};
  logic m_valid[2] = '{1'b0, 1'b0};
  logic m_dbz[2]   = '{1'b0, 1'b0};
  int   m_cnt[2]   = '{0, 0};
  logic [7:0] m_a[2] = '{8'd0, 8'd0};
  logic [7:0] m_b[2] = '{8'd0, 8'd0};
  logic [7:0] m_q[2] = '{8'd0, 8'd0};
  logic [7:0] m_r[2] = '{8'd0, 8'd0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_valid[i] <= 1'b0;
        m_cnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) begin
          if (v_or[i]) begin
            m_valid[i] <= 1'b0;
            m_busy[i]  <= 1'b0;
          end
        end else if (m_busy[i]) begin
          if (m_cnt[i] == 1) m_valid[i] <= 1'b1;
          m_cnt[i] <= m_cnt[i] - 1;
        end else if (v_iv[i]) begin
          m_busy[i] <= 1'b1;
          m_a[i]    <= v_a[i];
          m_b[i]    <= v_b[i];
          if (v_b[i] == 8'd0) begin
            m_q[i]     <= (i == 0) ? 8'hFF : 8'h1F;
            m_r[i]     <= v_a[i];
            m_dbz[i]   <= 1'b1;
            m_valid[i] <= 1'b1;
          end else begin
            m_q[i]   <= v_a[i] / v_b[i];
            m_r[i]   <= v_a[i] % v_b[i];
            m_dbz[i] <= 1'b0;
            m_cnt[i] <= (i == 0) ? 8 : 5;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "in_ready8" : "in_ready5", v_ir[i], !m_busy[i]);
      chk(i == 0 ? "out_valid8" : "out_valid5", v_ov[i], m_valid[i]);
      if (m_valid[i]) begin
        chk(i == 0 ? "q8" : "q5", v_q[i], m_q[i]);
        chk(i == 0 ? "r8" : "r5", v_r[i], m_r[i]);
        chk(i == 0 ? "dbz8" : "dbz5", v_dbz[i], m_dbz[i]);
        if (!m_dbz[i]) begin
          chk(i == 0 ? "identity8" : "identity5",
              int'(v_q[i]) * int'(m_b[i]) + int'(v_r[i]), m_a[i]);
          chk(i == 0 ? "r_lt_b8" : "r_lt_b5", v_r[i] < m_b[i], 1);
        end
      end
    end
  end

  // Directed N=8 op; exp_edges counts clock edges after the accept edge until out_valid.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input int hold,
                     input logic [7:0] eq, input logic [7:0] er, input logic exp_dbz,
                     input int exp_edges);
    int edges = 0;
    out_ready8 = (hold == 0);
    @(negedge clk);
    a8 = ta; b8 = tbv; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = ~ta; b8 = tbv + 8'd3;
    while (!out_valid8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("lat8", edges, exp_edges);
    chk("lit_q8", q8, eq);
    chk("lit_r8", r8, er);
    chk("lit_dbz8", dbz8, exp_dbz);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        if (k == 2) begin
          in_valid8 = 1'b1; a8 = 8'd9; b8 = 8'd2;
        end else begin
          in_valid8 = 1'b0;
        end
        @(posedge clk); #1;
        chk("hold_q8", q8, eq);
        chk("hold_r8", r8, er);
        chk("hold_valid8", out_valid8, 1);
        chk("hold_in_ready8", in_ready8, 0);
      end
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
    end
    @(posedge clk); #1;
    chk("in_ready_after8", in_ready8, 1);
    chk("out_valid_after8", out_valid8, 0);
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tbv);
    int guard = 0;
    @(negedge clk);
    a8 = ta; b8 = tbv; in_valid8 = 1'b1;
    #1;
    while (!in_ready8 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("send8_timeout", guard, 0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic send5(input logic [4:0] ta, input logic [4:0] tbv);
    int guard = 0;
    @(negedge clk);
    a5 = ta; b5 = tbv; in_valid5 = 1'b1;
    #1;
    while (!in_ready5 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("send5_timeout", guard, 0);
    @(posedge clk); #1;
    in_valid5 = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) begin
        out_ready8 = 1'($urandom_range(0, 1));
        out_ready5 = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL global_timeout: got running, expected finished at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    in_valid5 = 1'b0; a5 = '0; b5 = '0; out_ready5 = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready8", in_ready8, 1);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_q8", q8, 0);
    chk("rst_r8", r8, 0);
    chk("rst_dbz8", dbz8, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    op8(8'd200, 8'd7,  0, 8'd28,  8'd4,  1'b0, 8);
    op8(8'd255, 8'd1,  0, 8'd255, 8'd0,  1'b0, 8);
    op8(8'd5,   8'd9,  0, 8'd0,   8'd5,  1'b0, 8);
    op8(8'd0,   8'd13, 0, 8'd0,   8'd0,  1'b0, 8);
    op8(8'd77,  8'd0,  0, 8'd255, 8'd77, 1'b1, 0);
    op8(8'd77,  8'd3,  0, 8'd25,  8'd2,  1'b0, 8);
    op8(8'd100, 8'd10, 6, 8'd10,  8'd0,  1'b0, 8);

    // Abandon an operation mid-calculation.
    @(negedge clk);
    a8 = 8'd150; b8 = 8'd11; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid8", out_valid8, 0);
    chk("midrst_q8", q8, 0);
    chk("midrst_r8", r8, 0);
    chk("midrst_dbz8", dbz8, 0);
    chk("midrst_in_ready8", in_ready8, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    op8(8'd150, 8'd11, 0, 8'd13, 8'd7, 1'b0, 8);

    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send8(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          send5(5'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
        end
      end
    join
    rand_rdy = 1'b0;
    @(negedge clk);
    out_ready8 = 1'b1;
    out_ready5 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_in_ready8", in_ready8, 1);
    chk("drain_in_ready5", in_ready5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
